// File: rtl/ycc_rgb_conv_pipe_if.sv
// Stream bundle for the YCbCr-to-RGB converter: Y/Cb/Cr beat in, R/G/B pixel out.
// The slave modport is the converter's view; the master modport is the view of its surroundings.
interface ycc_rgb_conv_pipe_if #(
   parameter int DATA_W = 8
);
   logic              conv_en;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_y;
   logic [DATA_W-1:0] s_cb;
   logic [DATA_W-1:0] s_cr;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_r;
   logic [DATA_W-1:0] m_g;
   logic [DATA_W-1:0] m_b;

   modport slave (
      input  conv_en, s_valid, s_y, s_cb, s_cr, m_ready,
      output s_ready, m_valid, m_r, m_g, m_b
   );

   modport master (
      output conv_en, s_valid, s_y, s_cb, s_cr, m_ready,
      input  s_ready, m_valid, m_r, m_g, m_b
   );
endinterface

// File: rtl/ycc_rgb_conv_pipe.sv
// Three-stage fixed-point YCbCr-to-RGB converter with rounding, saturation and a per-beat
// passthrough mode. All stages advance together whenever the output is empty or being taken.
module ycc_rgb_conv_pipe #(
   parameter int DATA_W = 8,
   parameter int FRAC_W = 16,
   parameter int K_RCR  = 91881,
   parameter int K_GCB  = 22554,
   parameter int K_GCR  = 46802,
   parameter int K_BCB  = 116130
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ycc_rgb_conv_pipe_if.slave    bus
);
   localparam int DW1   = DATA_W + 1;
   localparam int ACC_W = DATA_W + FRAC_W + 4;

   localparam logic signed [DW1-1:0]   MID  = DW1'(1) <<< (DATA_W - 1);
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_W - 1);
   localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) <<< DATA_W) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] KR   = ACC_W'(K_RCR);
   localparam logic signed [ACC_W-1:0] KGB  = ACC_W'(K_GCB);
   localparam logic signed [ACC_W-1:0] KGR  = ACC_W'(K_GCR);
   localparam logic signed [ACC_W-1:0] KB   = ACC_W'(K_BCB);

   logic                    adv;
   logic                    v1_reg, v2_reg, v3_reg;
   logic                    en1_reg, en2_reg;
   logic [DATA_W-1:0]       raw_in [3];
   logic [DATA_W-1:0]       raw1_reg [3];
   logic [DATA_W-1:0]       raw2_reg [3];
   logic signed [DW1-1:0]   dcb_next, dcr_next;
   logic signed [DW1-1:0]   dcb1_reg, dcr1_reg;
   logic signed [ACC_W-1:0] dcb_ext, dcr_ext;
   logic signed [ACC_W-1:0] yq_next;
   logic signed [ACC_W-1:0] yq2_reg;
   logic signed [ACC_W-1:0] prod_next [3];
   logic signed [ACC_W-1:0] prod2_reg [3];
   logic [DATA_W-1:0]       rgb_next [3];
   logic [DATA_W-1:0]       rgb_reg [3];

   // A held output blocks every stage, so bubbles stay where they are during a stall.
   assign adv         = !v3_reg | bus.m_ready;
   assign bus.s_ready = adv;

   assign raw_in[0] = bus.s_y;
   assign raw_in[1] = bus.s_cb;
   assign raw_in[2] = bus.s_cr;

   assign dcb_next = $signed({1'b0, bus.s_cb}) - MID;
   assign dcr_next = $signed({1'b0, bus.s_cr}) - MID;

   assign dcb_ext = ACC_W'(dcb1_reg);
   assign dcr_ext = ACC_W'(dcr1_reg);
   assign yq_next = $signed(ACC_W'(raw1_reg[0])) <<< FRAC_W;

   assign prod_next[0] = KR * dcr_ext;
   assign prod_next[1] = KGB * dcb_ext + KGR * dcr_ext;
   assign prod_next[2] = KB * dcb_ext;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_ch
         logic signed [ACC_W-1:0] acc;
         logic signed [ACC_W-1:0] shr;

         // Green subtracts both chroma terms; red and blue add theirs.
         if (gi == 1) begin : g_sub
            assign acc = yq2_reg - prod2_reg[gi] + HALF;
         end else begin : g_add
            assign acc = yq2_reg + prod2_reg[gi] + HALF;
         end

         assign shr = acc >>> FRAC_W;
         assign rgb_next[gi] = !en2_reg      ? raw2_reg[gi] :
                               shr[ACC_W-1]  ? '0 :
                               (shr > MAXV)  ? '1 : shr[DATA_W-1:0];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_reg   <= 1'b0;
         v2_reg   <= 1'b0;
         v3_reg   <= 1'b0;
         en1_reg  <= 1'b0;
         en2_reg  <= 1'b0;
         dcb1_reg <= '0;
         dcr1_reg <= '0;
         yq2_reg  <= '0;
         for (int i = 0; i < 3; i++) begin
            raw1_reg[i]  <= '0;
            raw2_reg[i]  <= '0;
            prod2_reg[i] <= '0;
            rgb_reg[i]   <= '0;
         end
      end else if (adv) begin
         v1_reg <= bus.s_valid;
         v2_reg <= v1_reg;
         v3_reg <= v2_reg;
         if (bus.s_valid) begin
            en1_reg  <= bus.conv_en;
            raw1_reg <= raw_in;
            dcb1_reg <= dcb_next;
            dcr1_reg <= dcr_next;
         end
         if (v1_reg) begin
            en2_reg   <= en1_reg;
            raw2_reg  <= raw1_reg;
            yq2_reg   <= yq_next;
            prod2_reg <= prod_next;
         end
         if (v2_reg) begin
            rgb_reg <= rgb_next;
         end
      end
   end

   assign bus.m_valid = v3_reg;
   assign bus.m_r     = rgb_reg[0];
   assign bus.m_g     = rgb_reg[1];
   assign bus.m_b     = rgb_reg[2];
endmodule
